// File: rtl/kws_pkg.sv
// Shared definitions for the keyword-spotting classifier pipeline:
// decision FSM encoding and debounce/drop counter widths.
package kws_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2,
      ST_REPORT = 2'd3
   } kws_state_e;

   localparam int CONSEC_W  = 4;
   localparam int RUN_CNT_W = 4;
   localparam int HOLDOFF_W = 8;
   localparam int DROP_W    = 8;

   localparam logic [RUN_CNT_W-1:0] RUN_CNT_ONE = 4'd1;
   localparam logic [RUN_CNT_W-1:0] RUN_CNT_MAX = 4'd15;
   localparam logic [DROP_W-1:0]    DROP_MAX    = 8'd255;

endpackage

// File: rtl/kws_debounce.sv
// Keyword debounce: candidate qualification, consecutive-run counting and
// post-detection holdoff. State advances only on decide_en cycles.
module kws_debounce
   import kws_pkg::*;
#(
   parameter int NUM_CLASSES = 8,
   parameter int ACTIV_BITS  = 16,
   parameter int BG_CLASS    = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           decide_en,
   input  logic [$clog2(NUM_CLASSES)-1:0] best_idx,
   input  logic [ACTIV_BITS-1:0]          best_score,
   input  logic [ACTIV_BITS-1:0]          threshold,
   input  logic [CONSEC_W-1:0]            consec_required,
   input  logic [HOLDOFF_W-1:0]           holdoff_frames,
   output logic                           detect
);

   localparam int IDX_W = $clog2(NUM_CLASSES);
   localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(BG_CLASS);

   logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
   logic [IDX_W-1:0]     prev_class_q, prev_class_d;
   logic                 candidate_s;
   logic [RUN_CNT_W-1:0] run_next_s;
   logic [RUN_CNT_W-1:0] need_s;

   // Next debounce state and the detection decision for the current frame
   always_comb begin
      run_cnt_d    = run_cnt_q;
      holdoff_d    = holdoff_q;
      prev_class_d = prev_class_q;
      detect       = 1'b0;
      run_next_s   = '0;
      candidate_s  = ($signed(best_score) >= $signed(threshold)) && (best_idx != BG_IDX);
      need_s       = (consec_required == '0) ? RUN_CNT_ONE : RUN_CNT_W'(consec_required);
      if (decide_en) begin
         if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - 8'd1;
            run_cnt_d = '0;
         end else begin
            if (candidate_s && (best_idx == prev_class_q) && (run_cnt_q != '0)) begin
               run_next_s = (run_cnt_q == RUN_CNT_MAX) ? RUN_CNT_MAX : run_cnt_q + 4'd1;
            end else begin
               run_next_s = candidate_s ? RUN_CNT_ONE : '0;
            end
            prev_class_d = best_idx;
            if (run_next_s >= need_s) begin
               detect    = 1'b1;
               run_cnt_d = '0;
               holdoff_d = holdoff_frames;
            end else begin
               run_cnt_d = run_next_s;
            end
         end
      end else begin
         detect = 1'b0;
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q    <= '0;
         holdoff_q    <= '0;
         prev_class_q <= BG_IDX;
      end else begin
         run_cnt_q    <= run_cnt_d;
         holdoff_q    <= holdoff_d;
         prev_class_q <= prev_class_d;
      end
   end

endmodule

// File: rtl/kws_decision.sv
// Keyword-spotting decision stage: serial argmax over one frame of class
// scores, debounced keyword detection and dropped-frame accounting.
module kws_decision
   import kws_pkg::*;
#(
   parameter int NUM_CLASSES = 8,
   parameter int ACTIV_BITS  = 16,
   parameter int BG_CLASS    = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
   input  logic                              data_valid,
   output logic                              in_ready,
   input  logic [ACTIV_BITS-1:0]             threshold,
   input  logic [CONSEC_W-1:0]               consec_required,
   input  logic [HOLDOFF_W-1:0]              holdoff_frames,
   output logic [$clog2(NUM_CLASSES)-1:0]    class_idx,
   output logic [ACTIV_BITS-1:0]             class_score,
   output logic                              result_valid,
   output logic                              keyword_detected,
   output logic [DROP_W-1:0]                 drop_count
);

   localparam int IDX_W = $clog2(NUM_CLASSES);
   localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(NUM_CLASSES - 1);

   kws_state_e                        state_q, state_d;
   logic [NUM_CLASSES*ACTIV_BITS-1:0] frame_q, frame_d;
   logic signed [ACTIV_BITS-1:0]      best_q, best_d;
   logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
   logic [IDX_W-1:0]                  elem_cnt_q, elem_cnt_d;
   logic                              in_ready_q, in_ready_d;
   logic [IDX_W-1:0]                  class_idx_q, class_idx_d;
   logic [ACTIV_BITS-1:0]             class_score_q, class_score_d;
   logic                              result_valid_q, result_valid_d;
   logic                              keyword_q, keyword_d;
   logic [DROP_W-1:0]                 drop_q, drop_d;
   logic signed [ACTIV_BITS-1:0]      elem_s;
   logic                              accept_s;
   logic                              detect_s;

   assign elem_s   = frame_q[int'(elem_cnt_q)*ACTIV_BITS +: ACTIV_BITS];
   assign accept_s = data_valid && in_ready_q;

   kws_debounce #(
      .NUM_CLASSES (NUM_CLASSES),
      .ACTIV_BITS  (ACTIV_BITS),
      .BG_CLASS    (BG_CLASS)
   ) u_debounce (
      .clk             (clk),
      .rst_n           (rst_n),
      .decide_en       (state_q == ST_DECIDE),
      .best_idx        (best_idx_q),
      .best_score      (best_q),
      .threshold       (threshold),
      .consec_required (consec_required),
      .holdoff_frames  (holdoff_frames),
      .detect          (detect_s)
   );

   // FSM next state, argmax datapath and registered output values.
   // REPORT can take the next frame directly so a busy stream sees
   // one frame every NUM_CLASSES+1 cycles.
   always_comb begin
      state_d        = state_q;
      frame_d        = frame_q;
      best_d         = best_q;
      best_idx_d     = best_idx_q;
      elem_cnt_d     = elem_cnt_q;
      class_idx_d    = class_idx_q;
      class_score_d  = class_score_q;
      result_valid_d = 1'b0;
      keyword_d      = 1'b0;
      case (state_q)
         ST_IDLE, ST_REPORT: begin
            if (accept_s) begin
               frame_d    = data_in;
               best_d     = data_in[ACTIV_BITS-1:0];
               best_idx_d = '0;
               elem_cnt_d = IDX_W'(1);
               state_d    = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            // Strictly greater: ties keep the lowest class index
            if (elem_s > best_q) begin
               best_d     = elem_s;
               best_idx_d = elem_cnt_q;
            end else begin
               best_d = best_q;
            end
            if (elem_cnt_q == LAST_ELEM) begin
               state_d = ST_DECIDE;
            end else begin
               elem_cnt_d = elem_cnt_q + IDX_W'(1);
            end
         end
         ST_DECIDE: begin
            state_d        = ST_REPORT;
            result_valid_d = 1'b1;
            keyword_d      = detect_s;
            class_idx_d    = best_idx_q;
            class_score_d  = best_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE) || (state_d == ST_REPORT);
      if (data_valid && !in_ready_q && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // State and output registers; reset discards any in-flight frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         frame_q        <= '0;
         best_q         <= '0;
         best_idx_q     <= '0;
         elem_cnt_q     <= '0;
         in_ready_q     <= 1'b1;
         class_idx_q    <= '0;
         class_score_q  <= '0;
         result_valid_q <= 1'b0;
         keyword_q      <= 1'b0;
         drop_q         <= '0;
      end else begin
         state_q        <= state_d;
         frame_q        <= frame_d;
         best_q         <= best_d;
         best_idx_q     <= best_idx_d;
         elem_cnt_q     <= elem_cnt_d;
         in_ready_q     <= in_ready_d;
         class_idx_q    <= class_idx_d;
         class_score_q  <= class_score_d;
         result_valid_q <= result_valid_d;
         keyword_q      <= keyword_d;
         drop_q         <= drop_d;
      end
   end

   assign in_ready         = in_ready_q;
   assign class_idx        = class_idx_q;
   assign class_score      = class_score_q;
   assign result_valid     = result_valid_q;
   assign keyword_detected = keyword_q;
   assign drop_count       = drop_q;

endmodule

// File: tb/tb_kws_decision.sv
// Randomized self-checking bench for kws_decision against a frame-level
// reference model of argmax, debounce and drop accounting.
module tb_kws_decision;

   localparam int N  = 8;
   localparam int W  = 16;
   localparam int BG = 0;
   localparam int IW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*W-1:0] data_in = '0;
   logic           data_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   threshold = '0;
   logic [3:0]     consec_required = 4'd1;
   logic [7:0]     holdoff_frames = 8'd0;
   logic [IW-1:0]  class_idx;
   logic [W-1:0]   class_score;
   logic           result_valid;
   logic           keyword_detected;
   logic [7:0]     drop_count;

   int n_checks = 0;
   int n_fail   = 0;
   int m_run, m_hold, m_prev;

   kws_decision #(.NUM_CLASSES(N), .ACTIV_BITS(W), .BG_CLASS(BG)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_in          (data_in),
      .data_valid       (data_valid),
      .in_ready         (in_ready),
      .threshold        (threshold),
      .consec_required  (consec_required),
      .holdoff_frames   (holdoff_frames),
      .class_idx        (class_idx),
      .class_score      (class_score),
      .result_valid     (result_valid),
      .keyword_detected (keyword_detected),
      .drop_count       (drop_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int score_of(input logic [N*W-1:0] f, input int k);
      logic signed [W-1:0] v;
      v = f[k*W +: W];
      return int'(v);
   endfunction

   task automatic model_reset();
      m_run  = 0;
      m_hold = 0;
      m_prev = BG;
   endtask

   // Reference: winner = lowest index holding the maximum score, then debounce rules
   task automatic model_frame(input logic [N*W-1:0] f, input int thr, input int consec,
                              input int hold, output int e_idx, output int e_score,
                              output int e_det);
      int mx, need;
      bit cand;
      mx = score_of(f, 0);
      for (int k = 1; k < N; k++) if (score_of(f, k) > mx) mx = score_of(f, k);
      e_idx = -1;
      for (int k = 0; k < N; k++) if (e_idx < 0 && score_of(f, k) == mx) e_idx = k;
      e_score = mx;
      cand = (mx >= thr) && (e_idx != BG);
      e_det = 0;
      if (m_hold > 0) begin
         m_hold--;
         m_run = 0;
      end else begin
         if (cand && e_idx == m_prev && m_run > 0) m_run = (m_run >= 15) ? 15 : m_run + 1;
         else m_run = cand ? 1 : 0;
         m_prev = e_idx;
         need = (consec == 0) ? 1 : consec;
         if (m_run >= need) begin
            e_det  = 1;
            m_run  = 0;
            m_hold = hold;
         end
      end
   endtask

   task automatic do_frame(input string tag, input logic [N*W-1:0] f, input int thr,
                           input int consec, input int hold);
      int e_idx, e_score, e_det, lat;
      logic [W-1:0] es;
      threshold       = W'(thr);
      consec_required = 4'(consec);
      holdoff_frames  = 8'(hold);
      model_frame(f, thr, consec, hold, e_idx, e_score, e_det);
      es = W'(e_score);
      data_in    = f;
      data_valid = 1'b1;
      for (int t = 0; t < 20 && !in_ready; t++) begin
         @(posedge clk);
         #1;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (result_valid) lat = k;
      end
      check({tag, "_latency"}, 64'(lat), 64'(N));
      check({tag, "_idx"}, 64'(class_idx), 64'(e_idx));
      check({tag, "_score"}, 64'(class_score), 64'(es));
      check({tag, "_kw"}, 64'(keyword_detected), 64'(e_det));
   endtask

   function automatic logic [N*W-1:0] fill(input int base);
      logic [N*W-1:0] f;
      for (int k = 0; k < N; k++) f[k*W +: W] = W'(base);
      return f;
   endfunction

   initial begin
      logic [N*W-1:0] f;
      int e_idx, e_score, e_det, exp_drop, seen;
      logic [W-1:0] es;

      model_reset();
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_class_idx", 64'(class_idx), 64'd0);
      check("rst_class_score", 64'(class_score), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_kw", 64'(keyword_detected), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Tie between classes 1 and 2 resolves to 1, single-frame detection
      f = fill(1);
      f[0*W +: W] = 16'd5;
      f[1*W +: W] = 16'd100;
      f[2*W +: W] = 16'd100;
      f[3*W +: W] = 16'd7;
      do_frame("tie", f, 50, 1, 0);

      // Background winner never detects, even with the lowest threshold
      f = fill(3);
      f[0*W +: W] = 16'd500;
      do_frame("bg_a", f, -32768, 1, 0);
      do_frame("bg_b", f, -32768, 0, 0);

      // Three consecutive class-3 frames needed
      f = fill(-10);
      f[3*W +: W] = 16'd200;
      for (int i = 0; i < 3; i++) do_frame($sformatf("consec3_%0d", i), f, 100, 3, 0);

      // Holdoff of two frames after a detection
      f = fill(0);
      f[2*W +: W] = 16'd300;
      do_frame("hold_0", f, 100, 1, 2);
      for (int i = 1; i < 4; i++) do_frame($sformatf("hold_%0d", i), f, 100, 1, 2);

      // Randomized frames: mixes narrow-range scores (ties), wide scores, forced winners
      for (int i = 0; i < 60; i++) begin
         int mode, thr;
         mode = $urandom_range(0, 2);
         for (int k = 0; k < N; k++) begin
            if (mode == 0) f[k*W +: W] = W'(int'($urandom_range(0, 6)) - 3);
            else           f[k*W +: W] = W'($urandom);
         end
         if (mode == 2) begin
            int c;
            c = ($urandom_range(0, 2) == 0) ? BG : ((i % 2 == 0) ? 2 : 5);
            f[c*W +: W] = 16'sd20000;
         end
         thr = (mode == 0) ? int'($urandom_range(0, 4)) - 2
                           : int'($urandom_range(0, 40000)) - 20000;
         do_frame($sformatf("rnd%0d", i), f, thr, $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // Wait for the last REPORT to clear so the stream starts from IDLE
      @(posedge clk);
      #1;
      check("idle_before_stream", 64'(in_ready), 64'd1);

      // Continuous data_valid: accept every N+1 cycles, drops saturate at 255
      f = fill(2);
      f[0*W +: W] = 16'd1000;
      threshold       = 16'd0;
      consec_required = 4'd1;
      holdoff_frames  = 8'd0;
      data_in    = f;
      data_valid = 1'b1;
      for (int j = 0; j < 40 * (N + 1); j++) begin
         @(posedge clk);
         #1;
         exp_drop = j - j / (N + 1);
         if (exp_drop > 255) exp_drop = 255;
         check($sformatf("stream_drop_%0d", j), 64'(drop_count), 64'(exp_drop));
         check($sformatf("stream_rv_%0d", j), 64'(result_valid), 64'((j % (N + 1)) == N));
         if (j % (N + 1) == N) begin
            model_frame(f, 0, 1, 0, e_idx, e_score, e_det);
            check($sformatf("stream_idx_%0d", j), 64'(class_idx), 64'(e_idx));
            check($sformatf("stream_kw_%0d", j), 64'(keyword_detected), 64'(e_det));
         end
      end
      data_valid = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of SCAN discards the frame
      f = fill(0);
      f[4*W +: W] = 16'd900;
      data_in    = f;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_class_idx", 64'(class_idx), 64'd0);
      check("midrst_class_score", 64'(class_score), 64'd0);
      check("midrst_result_valid", 64'(result_valid), 64'd0);
      check("midrst_kw", 64'(keyword_detected), 64'd0);
      check("midrst_drop", 64'(drop_count), 64'd0);
      #2;
      rst_n = 1'b1;
      model_reset();
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (result_valid) seen = 1;
      end
      check("midrst_no_result", 64'(seen), 64'd0);
      do_frame("post_rst", f, 100, 1, 0);

      es = class_score;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
